// File: rtl/wnd_scan_pkg.sv
// wnd_scan_pkg: shared scan state encoding and default widths
package wnd_scan_pkg;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
  localparam int VECT_IND_WIDTH_DEF = 7;
  localparam int COUNT_WIDTH = VECT_IND_WIDTH_DEF + 1;
endpackage

// File: rtl/ff_wnd.sv
// ff_wnd: circular first-match search in a bitmap window starting at head
module ff_wnd #(
  parameter int VECT_WIDTH = 128,
  parameter int VECT_IND_WIDTH = 7,
  parameter int BLOCK_WIDTH = 2
) (
  input  logic [VECT_WIDTH-1:0]     vect_in,
  input  logic                      select_set_in,
  input  logic [VECT_IND_WIDTH-1:0] head_in,
  output logic                      val_out,
  output logic [VECT_IND_WIDTH-1:0] ind_out
);
  localparam int NB = (VECT_WIDTH + BLOCK_WIDTH - 1) / BLOCK_WIDTH;
  localparam logic [VECT_WIDTH-1:0] ONE = VECT_WIDTH'(1);
  localparam logic [VECT_WIDTH-1:0] BMASK = (ONE << BLOCK_WIDTH) - ONE;
  // block-level any-flags pick the lowest hit block, then the lowest bit inside it
  function automatic logic [VECT_IND_WIDTH:0] first_set(input logic [VECT_WIDTH-1:0] v);
    logic [VECT_IND_WIDTH:0] r;
    logic [VECT_WIDTH-1:0] t;
    logic [VECT_WIDTH-1:0] u;
    r = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      t = v >> (b * BLOCK_WIDTH);
      if (|(t & BMASK))
        for (int k = BLOCK_WIDTH - 1; k >= 0; k--) begin
          u = t >> k;
          if (u[0]) r = {1'b1, VECT_IND_WIDTH'(b * BLOCK_WIDTH + k)};
        end
    end
    return r;
  endfunction
  logic [VECT_WIDTH-1:0] match;
  logic [VECT_WIDTH-1:0] upper;
  logic [VECT_IND_WIDTH:0] f_hi;
  logic [VECT_IND_WIDTH:0] f_all;
  always_comb begin
    match = select_set_in ? vect_in : ~vect_in;
    upper = match & ~((ONE << head_in) - ONE);
    f_hi = first_set(upper);
    f_all = first_set(match);
    {val_out, ind_out} = f_hi[VECT_IND_WIDTH] ? f_hi : f_all;
  end
endmodule

// File: rtl/wnd_scan.sv
// wnd_scan: emits every matching window index, circularly from head, one per cycle
module wnd_scan import wnd_scan_pkg::*; #(
  parameter int VECT_WIDTH = 128,
  parameter int VECT_IND_WIDTH = 7,
  parameter int BLOCK_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_in,
  input  logic [VECT_WIDTH-1:0]     vect_in,
  input  logic                      select_set_in,
  input  logic [VECT_IND_WIDTH-1:0] head_in,
  input  logic                      abort_in,
  output logic                      busy_out,
  output logic                      idx_val_out,
  output logic [VECT_IND_WIDTH-1:0] idx_out,
  input  logic                      idx_rdy_in,
  output logic                      done_out,
  output logic [VECT_IND_WIDTH:0]   count_out
);
  localparam int CW = VECT_IND_WIDTH + 1;
  localparam logic [VECT_WIDTH-1:0] ONE = VECT_WIDTH'(1);
  state_t state, state_nxt;
  logic [VECT_WIDTH-1:0] pending;
  logic [VECT_IND_WIDTH-1:0] cursor;
  logic [VECT_IND_WIDTH-1:0] ff_ind;
  logic ff_val;
  logic slot_free;
  ff_wnd #(
    .VECT_WIDTH(VECT_WIDTH),
    .VECT_IND_WIDTH(VECT_IND_WIDTH),
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) u_ff_wnd (
    .vect_in(pending),
    .select_set_in(1'b1),
    .head_in(cursor),
    .val_out(ff_val),
    .ind_out(ff_ind)
  );
  assign slot_free = !idx_val_out || idx_rdy_in;
  assign busy_out = state == SCAN;
  always_comb begin
    state_nxt = state;
    if (abort_in) state_nxt = IDLE;
    else if (state == IDLE) state_nxt = start_in ? SCAN : IDLE;
    else if (slot_free && !ff_val) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      cursor <= '0;
      idx_out <= '0;
      idx_val_out <= 1'b0;
      done_out <= 1'b0;
      count_out <= '0;
    end else begin
      done_out <= 1'b0;
      if (idx_val_out && idx_rdy_in && count_out != CW'(VECT_WIDTH)) count_out <= count_out + 1'b1;
      if (abort_in) begin
        idx_val_out <= 1'b0;
        pending <= '0;
      end else if (state == IDLE) begin
        if (start_in) begin
          pending <= select_set_in ? vect_in : ~vect_in;
          cursor <= head_in;
          count_out <= '0;
        end
      end else if (slot_free) begin
        if (ff_val) begin
          idx_out <= ff_ind;
          idx_val_out <= 1'b1;
          pending <= pending & ~(ONE << ff_ind);
          cursor <= (ff_ind == VECT_IND_WIDTH'(VECT_WIDTH - 1)) ? '0 : ff_ind + 1'b1;
        end else begin
          idx_val_out <= 1'b0;
          done_out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wnd_scan.sv
// tb_wnd_scan: table-driven and randomized checks of wnd_scan against an index-list model
module tb_wnd_scan;
  logic clk = 1'b0;
  logic rst_n;
  logic start_in;
  logic [7:0] vect_in;
  logic select_set_in;
  logic [2:0] head_in;
  logic abort_in;
  logic busy_out;
  logic idx_val_out;
  logic [2:0] idx_out;
  logic idx_rdy_in;
  logic done_out;
  logic [3:0] count_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] vect;
    logic sel;
    logic [2:0] head;
    int mode;
    int n;
    logic [7:0][2:0] seq;
  } vec_t;
  vec_t tbl[6];

  wnd_scan #(.VECT_WIDTH(8), .VECT_IND_WIDTH(3), .BLOCK_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .vect_in(vect_in),
    .select_set_in(select_set_in), .head_in(head_in), .abort_in(abort_in),
    .busy_out(busy_out), .idx_val_out(idx_val_out), .idx_out(idx_out),
    .idx_rdy_in(idx_rdy_in), .done_out(done_out), .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected emission list: walk head..7 then 0..head-1, keep bits equal to sel
  task automatic build(input logic [7:0] v, input logic s, input logic [2:0] h,
                       output int n, output logic [7:0][2:0] seq);
    int q[$];
    logic [7:0] t;
    for (int k = 0; k < 8; k++) begin
      t = v >> ((int'(h) + k) % 8);
      if (t[0] == s) q.push_back((int'(h) + k) % 8);
    end
    n = q.size();
    seq = '0;
    for (int j = 0; j < n; j++) seq[j] = 3'(q[j]);
  endtask

  // mode 0: always ready; 1: random ready plus stray starts; 2: ready low 5 cycles on first valid
  task automatic scan(input logic [7:0] v, input logic s, input logic [2:0] h,
                      input int mode, input int n, input logic [7:0][2:0] seq);
    int k, cyc, lx, bp;
    logic pv, pr, done_seen;
    logic [2:0] pi;
    vect_in = v; select_set_in = s; head_in = h; start_in = 1'b1; idx_rdy_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    vect_in = 8'($urandom);
    head_in = 3'($urandom);
    check("busy_after_start", busy_out, 1);
    check("val_after_start", idx_val_out, 0);
    k = 0; cyc = 1; lx = 0; bp = 0; pv = 0; pr = 0; pi = '0; done_seen = 0;
    while (!done_seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done_out) begin
        done_seen = 1;
        check("done_cycle", cyc, (mode == 0 || n == 0) ? n + 2 : lx + 1);
        check("xfer_total", k, n);
        check("busy_with_done", busy_out, 0);
        check("val_with_done", idx_val_out, 0);
        check("count_final", count_out, n);
      end else begin
        if (pv && !pr) begin
          check("hold_val", idx_val_out, 1);
          check("hold_idx", idx_out, pi);
        end else if (idx_val_out) begin
          check("idx_in_range", k < n, 1);
          if (k < n) check("idx_order", idx_out, seq[k]);
        end
        if (idx_val_out && k == 0 && !pv) check("first_latency", cyc, 2);
        if (mode == 0 && k < n) check("rate_val", idx_val_out, 1);
        if (mode == 1) begin
          idx_rdy_in = 1'($urandom_range(0, 1));
          start_in = ($urandom_range(0, 3) == 0);
        end else if (mode == 2 && idx_val_out && bp < 5) begin
          idx_rdy_in = 1'b0;
          bp++;
        end else idx_rdy_in = 1'b1;
        if (idx_val_out && idx_rdy_in) begin
          k++;
          lx = cyc;
        end
        pv = idx_val_out; pr = idx_rdy_in; pi = idx_out;
      end
    end
    if (!done_seen) check("done_timeout", 0, 1);
    start_in = 1'b0;
    idx_rdy_in = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0][2:0] seq;
    logic [7:0] v;
    logic s;
    logic [2:0] h;
    tbl[0] = '{8'hA6, 1'b1, 3'd3, 0, 4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd7, 3'd5}};
    tbl[1] = '{8'hA6, 1'b0, 3'd3, 0, 4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd4, 3'd3}};
    tbl[2] = '{8'hFF, 1'b1, 3'd7, 2, 8, {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7}};
    tbl[3] = '{8'h00, 1'b1, 3'd2, 0, 0, 24'd0};
    tbl[4] = '{8'hFF, 1'b0, 3'd0, 0, 0, 24'd0};
    tbl[5] = '{8'h01, 1'b1, 3'd1, 0, 1, 24'd0};
    rst_n = 1'b0; start_in = 1'b0; vect_in = '0; select_set_in = 1'b0;
    head_in = '0; abort_in = 1'b0; idx_rdy_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_out, 0);
    check("rst_val", idx_val_out, 0);
    check("rst_idx", idx_out, 0);
    check("rst_done", done_out, 0);
    check("rst_count", count_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) scan(tbl[i].vect, tbl[i].sel, tbl[i].head, tbl[i].mode, tbl[i].n, tbl[i].seq);

    // empty window with a start pulse during its single busy cycle
    vect_in = 8'h00; select_set_in = 1'b1; head_in = 3'd0; start_in = 1'b1;
    @(negedge clk);
    check("empty_busy", busy_out, 1);
    vect_in = 8'hFF; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("empty_done", done_out, 1);
    check("empty_val", idx_val_out, 0);
    @(negedge clk);
    check("busy_start_ignored", busy_out, 0);
    check("empty_done_pulse", done_out, 0);

    // abort after two transfers
    vect_in = 8'hFF; select_set_in = 1'b1; head_in = 3'd0; start_in = 1'b1; idx_rdy_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    @(negedge clk);
    check("abort_idx0", idx_out, 0);
    @(negedge clk);
    check("abort_idx1", idx_out, 1);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    check("abort_val", idx_val_out, 0);
    check("abort_busy", busy_out, 0);
    check("abort_done", done_out, 0);
    check("abort_count", count_out, 2);
    @(negedge clk);
    check("abort_no_done", done_out, 0);
    check("abort_idle", busy_out, 0);
    build(8'h3C, 1'b1, 3'd5, n, seq);
    scan(8'h3C, 1'b1, 3'd5, 0, n, seq);

    for (int i = 0; i < 30; i++) begin
      v = 8'($urandom); s = 1'($urandom); h = 3'($urandom);
      build(v, s, h, n, seq);
      scan(v, s, h, (i % 3 == 0) ? 0 : 1, n, seq);
    end

    // asynchronous reset mid-scan
    vect_in = 8'hFF; select_set_in = 1'b1; head_in = 3'd4; start_in = 1'b1; idx_rdy_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_count", count_out, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_out, 0);
    check("arst_val", idx_val_out, 0);
    check("arst_idx", idx_out, 0);
    check("arst_done", done_out, 0);
    check("arst_count", count_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy_out, 0);
    check("post_rst_done", done_out, 0);
    check("post_rst_val", idx_val_out, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wnd_scan.md
Name: wnd_scan

Overview:
- Sequential iterator that sits directly downstream of the ff_wnd window search.
- On start it snapshots a bitmap window (ack or loss bitmap) and a head pointer.
- It walks the window circularly from head, using one ff_wnd instance per cycle, and emits every matching bit index over a valid/ready stream.
- Each emitted bit is cleared locally and the cursor advances. Consumers are retransmit and SACK-walk logic that need one index per cycle rather than only the first.

Parameters:
- VECT_WIDTH, 128: window bitmap width; need not be a power of two.
- VECT_IND_WIDTH, 7: index width; ceil(log2(VECT_WIDTH)).
- BLOCK_WIDTH, 2: passed through to ff_wnd.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start_in  in  1  begin a scan; sampled only in IDLE.
- vect_in  in  VECT_WIDTH  bitmap captured on start.
- select_set_in  in  1  1 = emit set bits, 0 = emit clear bits.
- head_in  in  VECT_IND_WIDTH  starting cursor; must be < VECT_WIDTH.
- abort_in  in  1  synchronous flush.
- busy_out  out  1  high while state is SCAN.
- idx_val_out  out  1  emitted index valid.
- idx_out  out  VECT_IND_WIDTH  emitted index.
- idx_rdy_in  in  1  consumer accept.
- done_out  out  1  one-cycle pulse when a scan completes.
- count_out  out  VECT_IND_WIDTH+1  indices accepted in the current or last scan.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, pending = 0, cursor = 0, and all outputs 0.
- States: IDLE and SCAN.
- IDLE, start_in = 1 at edge T:
  - pending[i] <= (vect_in[i] == select_set_in);
  - cursor <= head_in; count_out <= 0; state <= SCAN (busy_out high from T+1).
- ff_wnd is instantiated with vect = pending, select_set_in = 1 and head = cursor. Its output is combinational within the cycle.
- SCAN: a slot is free when !idx_val_out || idx_rdy_in.
  - Slot free and ff val = 1:
    - idx_out <= ind; idx_val_out <= 1; pending[ind] <= 0;
    - cursor <= (ind == VECT_WIDTH-1) ? 0 : ind+1.
  - Slot free and ff val = 0: idx_val_out <= 0; done_out <= 1 for the next cycle only; state <= IDLE.
  - Slot not free: hold idx_out, idx_val_out, pending and cursor.
- Latency and throughput:
  - First index is visible at T+2.
  - Sustained rate is one index per cycle while idx_rdy_in = 1.
  - done_out comes one cycle after the last index is accepted.
- Emission order: circular from head, i.e. head..VECT_WIDTH-1, then 0..head-1. Each bit is emitted exactly once.
- Handshake:
  - A transfer occurs when idx_val_out & idx_rdy_in.
  - count_out increments on each transfer and saturates at VECT_WIDTH.
  - idx_out is stable while valid and not ready.
- start_in while busy: ignored; the live scan is unaffected.
- abort_in (any state, highest priority over start_in in the same cycle):
  - idx_val_out <= 0; pending <= 0; state <= IDLE; no done_out.
  - A transfer coinciding with abort still counts.
- Empty match set: start at T, done_out high at T+2, idx_val_out never rises.
- Async reset mid-scan: all state and outputs clear immediately; no done_out; the scan is lost.
- done_out and busy_out are never high in the same cycle.

Decomposition:
- Shared bitmap_ops package:
  - state enum (IDLE = 0, SCAN = 1);
  - localparam COUNT_WIDTH = VECT_IND_WIDTH+1.
- One sub-module: the existing ff_wnd; no new children.
- Cursor wrap logic and the pending-clear decoder stay inline.

Test Plan:
- Set-bit scan with wrap: VECT_WIDTH=8, vect=8'b1010_0110, select=1, head=3, rdy=1 -> idx 5,7,1,2 on consecutive cycles from T+2; done_out at T+6; count_out=4.
- Clear-bit scan: same vect, select=0, head=3 -> idx 3,4,6,0; done_out after the 4th transfer; count_out=4.
- Backpressure: vect=8'hFF, head=7, rdy low for 5 cycles after first valid -> idx_out=7 held stable for 5 cycles; then 0,1,...,6 back-to-back; count_out=8.
- Empty window: vect=8'h00, select=1, start at T -> busy_out at T+1 only, done_out at T+2, idx_val_out never high; start_in pulsed during busy is ignored.
- Abort and reset:
  - abort_in after 2 transfers of 8'hFF scan -> idx_val_out low next cycle, IDLE, no done_out, count_out=2.
  - A new start then scans a fresh vect correctly.
  - rst_n low mid-scan -> all outputs 0 asynchronously.
